// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared definitions for the NoC packetizer slice:
//   - pkt_state_t      : packetizer FSM states (IDLE, SEND)
//   - flit_*_pos/lsb   : bit positions of the fields inside a flit, laid out
//                        as {head, tail, dest, payload} from MSB to LSB
//   - credit_cnt_width : width of a counter able to hold 0..credits
//   - num_flits        : flits needed to carry a packet of a given width
// -----------------------------------------------------------------------------
package noc_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } pkt_state_t;

  // Payload occupies the least significant bits of a flit.
  function automatic int flit_payload_lsb();
    return 0;
  endfunction

  // Destination field sits directly above the payload.
  function automatic int flit_dest_lsb(input int payload_w);
    return payload_w;
  endfunction

  function automatic int flit_tail_pos(input int payload_w, input int addr_w);
    return payload_w + addr_w;
  endfunction

  function automatic int flit_head_pos(input int payload_w, input int addr_w);
    return payload_w + addr_w + 1;
  endfunction

  function automatic int credit_cnt_width(input int credits);
    return $clog2(credits + 1);
  endfunction

  function automatic int num_flits(input int width, input int payload_w);
    return (width + payload_w - 1) / payload_w;
  endfunction

endpackage

// File: rtl/noc_packetizer_pkt_fifo.sv
// -----------------------------------------------------------------------------
// pkt_fifo
// Small circular packet FIFO with read/write pointers that wrap at DEPTH and
// an occupancy count of 0..DEPTH.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   push, wr_data     : write request and data (ignored when full)
//   pop               : read request (ignored when empty)
//   rd_data           : entry at the head of the FIFO
//   full, empty       : occupancy flags
//   count             : number of stored entries
// -----------------------------------------------------------------------------
module pkt_fifo
  import noc_pkg::*;
#(
  parameter int W     = 36,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [W-1:0]                 wr_data,
  input  logic                         pop,
  output logic [W-1:0]                 rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_push;
  logic             w_pop;
  logic [PTR_W-1:0] w_wr_ptr_next;
  logic [PTR_W-1:0] w_rd_ptr_next;

  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  assign w_wr_ptr_next = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
  assign w_rd_ptr_next = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);

  // Head entry is read combinationally: the packetizer must see a packet the
  // cycle after it is written so its head flit can issue on the next edge.
  assign rd_data = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= w_wr_ptr_next;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_next;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/noc_packetizer.sv
// -----------------------------------------------------------------------------
// noc_packetizer
// Buffers fixed-width packets from a node and serialises them into flits for
// one router input port, adding head/tail framing and credit flow control.
// Flit layout: {head, tail, dest, payload}; payload is taken MSB first and the
// last flit is zero padded in its low bits when WIDTH is not a multiple of
// FLIT_PAYLOAD.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   data_in         : packet data (WIDTH)
//   dest_in         : destination router index (N_ADDR_WIDTH)
//   valid_in        : packet valid; accepted when ready_out is also high
//   ready_out       : packet FIFO can accept (low during rst)
//   flit_out        : registered flit
//   flit_valid_out  : registered flit valid, one cycle per issued flit
//   credit_in       : one router buffer slot freed
//   credit_err      : sticky, credit returned while counter already full
//   busy            : FIFO non-empty or a flit on the output
// Optional build macro PACKETIZER_TRACE_EN: adds parameter NODE and a
// simulation-only trace of every head flit.
// -----------------------------------------------------------------------------
module noc_packetizer
  import noc_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int FLIT_PAYLOAD = 16,
  parameter int N            = 16,
  parameter int N_ADDR_WIDTH = $clog2(N),
  parameter int DEPTH        = 2,
  parameter int CREDITS      = 4
`ifdef PACKETIZER_TRACE_EN
  ,
  parameter int NODE         = 0
`endif
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [WIDTH-1:0]                    data_in,
  input  logic [N_ADDR_WIDTH-1:0]             dest_in,
  input  logic                                valid_in,
  output logic                                ready_out,
  output logic [FLIT_PAYLOAD+N_ADDR_WIDTH+1:0] flit_out,
  output logic                                flit_valid_out,
  input  logic                                credit_in,
  output logic                                credit_err,
  output logic                                busy
);

  localparam int NUM_FLITS   = num_flits(WIDTH, FLIT_PAYLOAD);
  localparam int PADDED_W    = NUM_FLITS * FLIT_PAYLOAD;
  localparam int PAD_W       = PADDED_W - WIDTH;
  localparam int IDX_W       = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1;
  localparam int CRED_W      = credit_cnt_width(CREDITS);
  localparam int FLIT_W      = FLIT_PAYLOAD + N_ADDR_WIDTH + 2;
  localparam int ENTRY_W     = WIDTH + N_ADDR_WIDTH;
  localparam int FIFO_CNT_W  = $clog2(DEPTH + 1);
  localparam int HEAD_POS    = flit_head_pos(FLIT_PAYLOAD, N_ADDR_WIDTH);
  localparam int TAIL_POS    = flit_tail_pos(FLIT_PAYLOAD, N_ADDR_WIDTH);
  localparam int DEST_LSB    = flit_dest_lsb(FLIT_PAYLOAD);
  localparam int PAYLOAD_LSB = flit_payload_lsb();

  // Registers
  pkt_state_t        r_state;
  logic [IDX_W-1:0]  r_flit_idx;
  logic [CRED_W-1:0] r_credit_cnt;
  logic              r_credit_err;
  logic [FLIT_W-1:0] r_flit_out;
  logic              r_flit_valid;

  // Next-state and datapath wires
  pkt_state_t        w_state_next;
  logic [IDX_W-1:0]  w_flit_idx_next;
  logic [CRED_W-1:0] w_credit_cnt_next;
  logic              w_credit_err_next;
  logic [FLIT_W-1:0] w_flit_out_next;
  logic              w_flit_valid_next;

  logic              w_push;
  logic              w_pop;
  logic [ENTRY_W-1:0] w_fifo_rd;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [FIFO_CNT_W-1:0] w_fifo_count;

  logic [WIDTH-1:0]        w_data;
  logic [N_ADDR_WIDTH-1:0] w_dest;
  logic [PADDED_W-1:0]     w_padded;
  logic [FLIT_PAYLOAD-1:0] w_payload;
  logic [FLIT_W-1:0]       w_flit;
  logic                    w_issue;
  logic                    w_is_tail;

  // ready_out depends only on occupancy, so a full FIFO never accepts even
  // in the cycle it pops.
  assign ready_out = !rst && !w_fifo_full;
  assign w_push    = valid_in && ready_out;

  pkt_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (w_push),
    .wr_data ({dest_in, data_in}),
    .pop     (w_pop),
    .rd_data (w_fifo_rd),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty),
    .count   (w_fifo_count)
  );

  assign w_data = w_fifo_rd[WIDTH-1:0];
  assign w_dest = w_fifo_rd[ENTRY_W-1:WIDTH];

  // Left-align the packet so zero padding lands in the low bits of the last
  // flit, then pick flit r_flit_idx counting from the MSB end.
  assign w_padded  = PADDED_W'(w_data) << PAD_W;
  assign w_payload = FLIT_PAYLOAD'(w_padded >> (FLIT_PAYLOAD * (NUM_FLITS - 1 - int'(r_flit_idx))));

  assign w_issue   = !w_fifo_empty && (r_credit_cnt != '0);
  assign w_is_tail = (r_flit_idx == IDX_W'(NUM_FLITS - 1));

  always_comb begin
    w_flit = '0;
    w_flit[HEAD_POS] = (r_flit_idx == '0);
    w_flit[TAIL_POS] = w_is_tail;
    w_flit[DEST_LSB +: N_ADDR_WIDTH]      = w_dest;
    w_flit[PAYLOAD_LSB +: FLIT_PAYLOAD]   = w_payload;
  end

  // FSM state register and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_flit_idx   <= '0;
      r_credit_cnt <= CRED_W'(CREDITS);
      r_credit_err <= 1'b0;
      r_flit_out   <= '0;
      r_flit_valid <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_flit_idx   <= w_flit_idx_next;
      r_credit_cnt <= w_credit_cnt_next;
      r_credit_err <= w_credit_err_next;
      r_flit_out   <= w_flit_out_next;
      r_flit_valid <= w_flit_valid_next;
    end
  end

  // FSM next state and flit issue
  always_comb begin
    w_state_next      = r_state;
    w_flit_idx_next   = r_flit_idx;
    w_flit_out_next   = '0;
    w_flit_valid_next = 1'b0;
    w_pop             = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_issue) begin
          w_flit_out_next   = w_flit;
          w_flit_valid_next = 1'b1;
          if (NUM_FLITS == 1) begin
            // Single-flit packet: head and tail at once, stay in IDLE so the
            // next packet can issue on the following edge.
            w_pop = 1'b1;
          end else begin
            w_flit_idx_next = IDX_W'(1);
            w_state_next    = SEND;
          end
        end
      end
      SEND: begin
        if (w_issue) begin
          w_flit_out_next   = w_flit;
          w_flit_valid_next = 1'b1;
          if (w_is_tail) begin
            w_pop           = 1'b1;
            w_flit_idx_next = '0;
            w_state_next    = IDLE;
          end else begin
            w_flit_idx_next = r_flit_idx + IDX_W'(1);
          end
        end
      end
      default: begin
        w_state_next    = IDLE;
        w_flit_idx_next = '0;
      end
    endcase
  end

  // Credit counter: an issue and a returned credit in the same cycle cancel.
  // A credit returned while already full is a router protocol error; the
  // counter holds and the sticky flag records it.
  always_comb begin
    w_credit_cnt_next = r_credit_cnt;
    w_credit_err_next = r_credit_err;
    case ({w_issue, credit_in})
      2'b10: w_credit_cnt_next = r_credit_cnt - CRED_W'(1);
      2'b01: begin
        if (r_credit_cnt == CRED_W'(CREDITS)) begin
          w_credit_err_next = 1'b1;
        end else begin
          w_credit_cnt_next = r_credit_cnt + CRED_W'(1);
        end
      end
      default: w_credit_cnt_next = r_credit_cnt;
    endcase
  end

  assign flit_out       = r_flit_out;
  assign flit_valid_out = r_flit_valid;
  assign credit_err     = r_credit_err;
  assign busy           = (w_fifo_count != '0) || r_flit_valid;

`ifdef PACKETIZER_TRACE_EN
  always @(posedge clk) begin
    if (!rst && w_issue && (r_flit_idx == '0)) begin
      $display("PKT; time=%d; from=%d; to=%d; flits=%d;",
               $time, NODE, w_dest, NUM_FLITS);
    end
  end
`endif

endmodule

// File: tb/tb_noc_packetizer.sv
// -----------------------------------------------------------------------------
// tb_noc_packetizer
// Three packetizer instances: A (WIDTH=32, CREDITS=4), B (WIDTH=20, CREDITS=1,
// padded last flit) and C (WIDTH=16, single-flit packets). Expected flits are
// pushed to a tagged queue when a packet is accepted and compared whenever an
// instance shows a valid flit.
// -----------------------------------------------------------------------------
module tb_noc_packetizer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A
  logic [31:0] a_data = '0;
  logic [3:0]  a_dest = '0;
  logic        a_valid = 1'b0, a_ready, a_fv, a_credit = 1'b0, a_err, a_busy;
  logic [21:0] a_flit;
  // Instance B
  logic [19:0] b_data = '0;
  logic [3:0]  b_dest = '0;
  logic        b_valid = 1'b0, b_ready, b_fv, b_credit = 1'b0, b_err, b_busy;
  logic [21:0] b_flit;
  // Instance C
  logic [15:0] c_data = '0;
  logic [3:0]  c_dest = '0;
  logic        c_valid = 1'b0, c_ready, c_fv, c_credit = 1'b0, c_err, c_busy;
  logic [21:0] c_flit;

  noc_packetizer #(.WIDTH(32), .FLIT_PAYLOAD(16), .N(16), .DEPTH(2), .CREDITS(4)) u_a (
    .clk(clk), .rst(rst), .data_in(a_data), .dest_in(a_dest), .valid_in(a_valid),
    .ready_out(a_ready), .flit_out(a_flit), .flit_valid_out(a_fv),
    .credit_in(a_credit), .credit_err(a_err), .busy(a_busy));

  noc_packetizer #(.WIDTH(20), .FLIT_PAYLOAD(16), .N(16), .DEPTH(2), .CREDITS(1)) u_b (
    .clk(clk), .rst(rst), .data_in(b_data), .dest_in(b_dest), .valid_in(b_valid),
    .ready_out(b_ready), .flit_out(b_flit), .flit_valid_out(b_fv),
    .credit_in(b_credit), .credit_err(b_err), .busy(b_busy));

  noc_packetizer #(.WIDTH(16), .FLIT_PAYLOAD(16), .N(16), .DEPTH(2), .CREDITS(4)) u_c (
    .clk(clk), .rst(rst), .data_in(c_data), .dest_in(c_dest), .valid_in(c_valid),
    .ready_out(c_ready), .flit_out(c_flit), .flit_valid_out(c_fv),
    .credit_in(c_credit), .credit_err(c_err), .busy(c_busy));

  int n_vec = 0;
  int n_err = 0;
  int n_seen [3] = '{0, 0, 0};
  logic [23:0] exp_q [$];   // {instance id, expected flit}

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected flits built from the packet: left-align in 32 bits, then cut
  // into 16-bit slices from the top.
  task automatic expect_pkt(input int d, input logic [31:0] data, input logic [3:0] dest);
    int width;
    int nf;
    logic [31:0] padded;
    width  = (d == 0) ? 32 : (d == 1) ? 20 : 16;
    nf     = (width + 15) / 16;
    padded = data << (32 - width);
    for (int i = 0; i < nf; i++) begin
      exp_q.push_back({2'(d), (i == 0), (i == nf - 1), dest, padded[31-16*i -: 16]});
    end
  endtask

  task automatic mon(input int d, input logic [21:0] f);
    logic [23:0] e;
    n_seen[d]++;
    n_vec++;
    assert (exp_q.size() != 0) else begin
      n_err++;
      $error("FAIL unexpected_flit dut=%0d observed=%0h expected=none", d, f);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check($sformatf("flit_dut%0d", d), {2'(d), f}, e);
    end
  endtask

  // One clock: compare outputs at the falling edge, then return 1 time unit
  // after the rising edge so inputs change away from the edge.
  task automatic tick();
    @(negedge clk);
    if (a_fv) mon(0, a_flit);
    if (b_fv) mon(1, b_flit);
    if (c_fv) mon(2, c_flit);
    @(posedge clk);
    #1;
  endtask

  function automatic logic ready_of(input int d);
    return (d == 0) ? a_ready : (d == 1) ? b_ready : c_ready;
  endfunction

  task automatic send(input int d, input logic [31:0] data, input logic [3:0] dest);
    logic rdy;
    rdy = ready_of(d);
    for (int k = 0; k < 30 && !rdy; k++) begin
      tick();
      rdy = ready_of(d);
    end
    check($sformatf("ready_wait_dut%0d", d), rdy, 1);
    case (d)
      0: begin a_valid = 1'b1; a_data = data; a_dest = dest; end
      1: begin b_valid = 1'b1; b_data = data[19:0]; b_dest = dest; end
      default: begin c_valid = 1'b1; c_data = data[15:0]; c_dest = dest; end
    endcase
    if (rdy) expect_pkt(d, data, dest);
    tick();
    a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
  endtask

  initial begin
    int base;
    logic acc;

    // ---- reset ----
    tick(); tick();
    check("ready_in_rst", a_ready, 0);
    rst = 1'b0;
    tick();
    check("rst_ready", a_ready, 1);
    check("rst_fv", a_fv, 0);
    check("rst_flit", a_flit, 0);
    check("rst_err", a_err, 0);
    check("rst_busy", a_busy, 0);
    check("rst_ready_b", b_ready, 1);

    // ---- A: 0xDEADBEEF to node 5, two flits on consecutive cycles ----
    send(0, 32'hDEADBEEF, 4'd5);
    check("head_latency", a_fv, 0);
    check("busy_after_accept", a_busy, 1);
    tick();
    check("flitA_valid", a_fv, 1);
    check("flitA", a_flit, {1'b1, 1'b0, 4'd5, 16'hDEAD});
    tick();
    check("flitB_valid", a_fv, 1);
    check("flitB", a_flit, {1'b0, 1'b1, 4'd5, 16'hBEEF});
    tick();
    check("drained_fv", a_fv, 0);
    check("drained_busy", a_busy, 0);

    // ---- A: two credits left, three packets -> only two flits issue ----
    base = n_seen[0];
    send(0, 32'h11112222, 4'd1);
    send(0, 32'h33334444, 4'd2);
    send(0, 32'h55556666, 4'd3);
    repeat (5) tick();
    check("stall_flits", n_seen[0] - base, 2);
    check("stall_fv", a_fv, 0);
    check("stall_ready", a_ready, 0);
    check("stall_busy", a_busy, 1);
    base = n_seen[0];
    for (int i = 0; i < 4; i++) begin
      a_credit = 1'b1; tick(); a_credit = 1'b0; tick(); tick();
      check($sformatf("credit_flit_%0d", i), n_seen[0] - base, i + 1);
    end
    check("resume_ready", a_ready, 1);
    check("resume_queue", exp_q.size(), 0);
    // Refill to exactly CREDITS: no error expected.
    for (int i = 0; i < 4; i++) begin
      a_credit = 1'b1; tick(); a_credit = 1'b0; tick();
    end
    check("refill_no_err", a_err, 0);

    // ---- A: back-to-back packets, no bubble between tail and head ----
    a_valid = 1'b1; a_data = 32'hA5A5_0F0F; a_dest = 4'd6;
    expect_pkt(0, 32'hA5A5_0F0F, 4'd6);
    tick();
    a_data = 32'h1234_5678; a_dest = 4'd7;
    expect_pkt(0, 32'h1234_5678, 4'd7);
    tick();
    a_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("b2b_valid_%0d", i), a_fv, 1);
      tick();
    end
    check("b2b_end", a_fv, 0);
    a_credit = 1'b1; repeat (4) tick(); a_credit = 1'b0;

    // ---- A: credit returned at full count -> sticky error, count holds ----
    a_credit = 1'b1; tick(); a_credit = 1'b0;
    check("credit_err_set", a_err, 1);
    repeat (3) tick();
    check("credit_err_sticky", a_err, 1);
    base = n_seen[0];
    send(0, 32'h0BAD_F00D, 4'd8);
    send(0, 32'h7777_8888, 4'd9);
    send(0, 32'h9999_AAAA, 4'd10);
    repeat (8) tick();
    check("credits_still_4", n_seen[0] - base, 4);

    // ---- A: reset mid-packet drops the tail ----
    rst = 1'b1; tick(); exp_q.delete(); rst = 1'b0;
    check("rst2_err", a_err, 0);
    check("rst2_busy", a_busy, 0);
    send(0, 32'hCAFE_F00D, 4'd9);
    tick();
    check("mid_head", a_flit, {1'b1, 1'b0, 4'd9, 16'hCAFE});
    rst = 1'b1;
    tick();
    exp_q.delete();
    rst = 1'b0;
    check("mid_rst_fv", a_fv, 0);
    check("mid_rst_flit", a_flit, 0);
    tick();
    check("no_tail", a_fv, 0);
    base = n_seen[0];
    send(0, 32'h0123_4567, 4'd10);
    send(0, 32'h89AB_CDEF, 4'd11);
    repeat (8) tick();
    check("fresh_full_credits", n_seen[0] - base, 4);
    check("fresh_queue", exp_q.size(), 0);

    // ---- B: WIDTH=20, CREDITS=1, padded last flit ----
    send(1, 32'h000A_BCDE, 4'd3);
    tick();
    check("pad_head", b_flit, {1'b1, 1'b0, 4'd3, 16'hABCD});
    repeat (3) tick();
    check("pad_stall_fv", b_fv, 0);
    check("pad_stall_busy", b_busy, 1);
    b_credit = 1'b1; tick(); b_credit = 1'b0; tick();
    check("pad_tail", b_flit, {1'b0, 1'b1, 4'd3, 16'hE000});
    tick();
    check("pad_done_busy", b_busy, 0);
    b_credit = 1'b1; tick(); b_credit = 1'b0;

    // ---- B: three packets, one credit: fill, stall, then one flit per credit ----
    base = n_seen[1];
    send(1, 32'h0001_2345, 4'd1);
    send(1, 32'h0006_789A, 4'd2);
    b_valid = 1'b1; b_data = 20'hBCDEF; b_dest = 4'd4;
    for (int i = 0; i < 3; i++) begin
      acc = b_valid && b_ready;
      if (acc) expect_pkt(1, 32'h000B_CDEF, 4'd4);
      tick();
      if (acc) b_valid = 1'b0;
    end
    check("fill_ready", b_ready, 0);
    check("fill_flits", n_seen[1] - base, 1);
    for (int p = 0; p < 5; p++) begin
      for (int s = 0; s < 3; s++) begin
        b_credit = (s == 0);
        acc = b_valid && b_ready;
        if (acc) expect_pkt(1, 32'h000B_CDEF, 4'd4);
        tick();
        if (acc) b_valid = 1'b0;
      end
      check($sformatf("b_credit_flit_%0d", p), n_seen[1] - base, p + 2);
    end
    b_credit = 1'b0;
    check("b_all_drained", exp_q.size(), 0);
    check("b_third_accepted", b_valid, 0);

    // ---- C: single-flit packets on consecutive cycles ----
    c_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      c_data = 16'h1000 + 16'(i); c_dest = 4'(i + 12);
      check($sformatf("c_ready_%0d", i), c_ready, 1);
      expect_pkt(2, 32'(c_data), c_dest);
      tick();
      if (i > 0) check($sformatf("c_valid_%0d", i), c_fv, 1);
    end
    c_valid = 1'b0;
    tick();
    check("c_valid_last", c_fv, 1);
    tick();
    check("c_end", c_fv, 0);
    check("c_queue", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
